kbd_cmd_controller: RTL and testbench

Parametrised keyboard command controller for the audio-playback datapath. It accepts one ASCII key per rising edge of the keyboard ready strobe. Each key is decoded into latched playback controls: pause, direction, and a saturating speed level. A restart command is held until the flash address generator acknowledges it. The block sits between the PS/2 keyboard receiver and the address generator and clock divider, and replaces the free-running level decoder of the previous generation.

---
 rtl/kbd_cmd_pkg.sv | 97 +++++++++
 rtl/kbd_cmd_controller_decoder.sv | 44 ++++
 rtl/kbd_cmd_controller.sv | 181 ++++++++++++++++++
 tb/tb_kbd_cmd_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_cmd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_cmd_pkg
// Shared definitions for the keyboard command controller:
//   - ASCII codes for the upper- and lowercase Latin letters
//   - cmd_t   : decoded keyboard command
//   - state_t : controller FSM state encoding
//   - ascii_to_upper : folds a lowercase letter onto its uppercase code
// No ports (package).
// -----------------------------------------------------------------------------
package kbd_cmd_pkg;

    // Uppercase letters
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_B = 8'h42;
    localparam logic [7:0] ASCII_UC_C = 8'h43;
    localparam logic [7:0] ASCII_UC_D = 8'h44;
    localparam logic [7:0] ASCII_UC_E = 8'h45;
    localparam logic [7:0] ASCII_UC_F = 8'h46;
    localparam logic [7:0] ASCII_UC_G = 8'h47;
    localparam logic [7:0] ASCII_UC_H = 8'h48;
    localparam logic [7:0] ASCII_UC_I = 8'h49;
    localparam logic [7:0] ASCII_UC_J = 8'h4A;
    localparam logic [7:0] ASCII_UC_K = 8'h4B;
    localparam logic [7:0] ASCII_UC_L = 8'h4C;
    localparam logic [7:0] ASCII_UC_M = 8'h4D;
    localparam logic [7:0] ASCII_UC_N = 8'h4E;
    localparam logic [7:0] ASCII_UC_O = 8'h4F;
    localparam logic [7:0] ASCII_UC_P = 8'h50;
    localparam logic [7:0] ASCII_UC_Q = 8'h51;
    localparam logic [7:0] ASCII_UC_R = 8'h52;
    localparam logic [7:0] ASCII_UC_S = 8'h53;
    localparam logic [7:0] ASCII_UC_T = 8'h54;
    localparam logic [7:0] ASCII_UC_U = 8'h55;
    localparam logic [7:0] ASCII_UC_V = 8'h56;
    localparam logic [7:0] ASCII_UC_W = 8'h57;
    localparam logic [7:0] ASCII_UC_X = 8'h58;
    localparam logic [7:0] ASCII_UC_Y = 8'h59;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;

    // Lowercase letters
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_B = 8'h62;
    localparam logic [7:0] ASCII_LC_C = 8'h63;
    localparam logic [7:0] ASCII_LC_D = 8'h64;
    localparam logic [7:0] ASCII_LC_E = 8'h65;
    localparam logic [7:0] ASCII_LC_F = 8'h66;
    localparam logic [7:0] ASCII_LC_G = 8'h67;
    localparam logic [7:0] ASCII_LC_H = 8'h68;
    localparam logic [7:0] ASCII_LC_I = 8'h69;
    localparam logic [7:0] ASCII_LC_J = 8'h6A;
    localparam logic [7:0] ASCII_LC_K = 8'h6B;
    localparam logic [7:0] ASCII_LC_L = 8'h6C;
    localparam logic [7:0] ASCII_LC_M = 8'h6D;
    localparam logic [7:0] ASCII_LC_N = 8'h6E;
    localparam logic [7:0] ASCII_LC_O = 8'h6F;
    localparam logic [7:0] ASCII_LC_P = 8'h70;
    localparam logic [7:0] ASCII_LC_Q = 8'h71;
    localparam logic [7:0] ASCII_LC_R = 8'h72;
    localparam logic [7:0] ASCII_LC_S = 8'h73;
    localparam logic [7:0] ASCII_LC_T = 8'h74;
    localparam logic [7:0] ASCII_LC_U = 8'h75;
    localparam logic [7:0] ASCII_LC_V = 8'h76;
    localparam logic [7:0] ASCII_LC_W = 8'h77;
    localparam logic [7:0] ASCII_LC_X = 8'h78;
    localparam logic [7:0] ASCII_LC_Y = 8'h79;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;

    // Distance between a lowercase letter and its uppercase counterpart
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

    typedef enum logic [3:0] {
        CMD_NONE    = 4'd0,
        CMD_PLAY    = 4'd1,
        CMD_PAUSE   = 4'd2,
        CMD_FWD     = 4'd3,
        CMD_BWD     = 4'd4,
        CMD_SPD_UP  = 4'd5,
        CMD_SPD_DN  = 4'd6,
        CMD_SPD_DEF = 4'd7,
        CMD_RESTART = 4'd8
    } cmd_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RESTART = 1'b1
    } state_t;

    // Map 'a'..'z' onto 'A'..'Z'; every other code passes through untouched.
    function automatic logic [7:0] ascii_to_upper(input logic [7:0] code);
        if ((code >= ASCII_LC_A) && (code <= ASCII_LC_Z)) begin
            return code - ASCII_CASE_OFFSET;
        end else begin
            return code;
        end
    endfunction

endpackage

// File: rtl/kbd_cmd_controller_decoder.sv
// -----------------------------------------------------------------------------
// kbd_ascii_decoder
// Purely combinational ASCII-to-command mapping.
// Parameters:
//   CASE_INSENSITIVE : 1 = lowercase letters decode like uppercase,
//                      0 = lowercase letters decode to CMD_NONE
// Ports:
//   ascii  in  8      ASCII code from the keyboard receiver
//   cmd    out cmd_t  decoded command (CMD_NONE for unrecognised codes)
// -----------------------------------------------------------------------------
module kbd_ascii_decoder
    import kbd_cmd_pkg::*;
#(
    parameter int CASE_INSENSITIVE = 1
) (
    input  logic [7:0] ascii,
    output cmd_t       cmd
);

    logic [7:0] code;

    // Optional case folding followed by the command lookup.
    always_comb begin
        code = ascii;
        cmd  = CMD_NONE;
        if (CASE_INSENSITIVE != 0) begin
            code = ascii_to_upper(ascii);
        end else begin
            code = ascii;
        end
        case (code)
            ASCII_UC_E: cmd = CMD_PLAY;
            ASCII_UC_D: cmd = CMD_PAUSE;
            ASCII_UC_F: cmd = CMD_FWD;
            ASCII_UC_B: cmd = CMD_BWD;
            ASCII_UC_U: cmd = CMD_SPD_UP;
            ASCII_UC_L: cmd = CMD_SPD_DN;
            ASCII_UC_K: cmd = CMD_SPD_DEF;
            ASCII_UC_R: cmd = CMD_RESTART;
            default:    cmd = CMD_NONE;
        endcase
    end

endmodule

// File: rtl/kbd_cmd_controller.sv
// -----------------------------------------------------------------------------
// kbd_cmd_controller
// Takes one ASCII key per rising edge of kbd_ready and turns it into latched
// playback controls (pause, direction, saturating speed). A restart command
// raises restart/busy until the address generator acknowledges it.
// Parameters:
//   NUM_SPEEDS       number of speed levels (>= 2)
//   DEFAULT_SPEED    speed after reset and after the K command
//   CASE_INSENSITIVE 1 = lowercase keys accepted
//   RESET_PAUSED     reset value of pause
//   SW               width of speed (derived)
// Ports:
//   clk           in   1   system clock
//   reset         in   1   asynchronous active-high reset
//   kbd_ready     in   1   keyboard strobe; a key is taken on its rising edge
//   kbd_ascii     in   8   key code, sampled with the rising edge of kbd_ready
//   restart_ack   in   1   address generator has reloaded its start address
//   restart       out  1   restart request, held until acknowledged
//   pause         out  1   1 = playback halted
//   direction     out  1   1 = forward, 0 = backward
//   speed         out  SW  current speed level
//   cmd_accepted  out  1   one-cycle pulse per executed command
//   busy          out  1   high while a restart is outstanding
// -----------------------------------------------------------------------------
module kbd_cmd_controller
    import kbd_cmd_pkg::*;
#(
    parameter int NUM_SPEEDS       = 8,
    parameter int DEFAULT_SPEED    = 3,
    parameter int CASE_INSENSITIVE = 1,
    parameter int RESET_PAUSED     = 1,
    parameter int SW               = $clog2(NUM_SPEEDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          kbd_ready,
    input  logic [7:0]    kbd_ascii,
    input  logic          restart_ack,
    output logic          restart,
    output logic          pause,
    output logic          direction,
    output logic [SW-1:0] speed,
    output logic          cmd_accepted,
    output logic          busy
);

    localparam logic [0:0]    IDLE       = 1'b0;
    localparam logic [0:0]    RESTART    = 1'b1;
    localparam logic [SW-1:0] SPEED_MAX  = SW'(NUM_SPEEDS - 1);
    localparam logic [SW-1:0] SPEED_DEF  = SW'(DEFAULT_SPEED);
    localparam logic          PAUSE_INIT = (RESET_PAUSED != 0);

    logic          kbd_ready_q;
    logic          strobe_s;
    cmd_t          cmd_s;
    logic [0:0]    state_r;
    logic [0:0]    state_nxt_s;
    logic          pause_nxt_s;
    logic          direction_nxt_s;
    logic [SW-1:0] speed_nxt_s;
    logic          accepted_nxt_s;

    // Saturating increment: holds at the top level.
    function automatic logic [SW-1:0] speed_up(input logic [SW-1:0] s);
        if (s == SPEED_MAX) begin
            return s;
        end else begin
            return s + SW'(1);
        end
    endfunction

    // Saturating decrement: holds at zero.
    function automatic logic [SW-1:0] speed_down(input logic [SW-1:0] s);
        if (s == SW'(0)) begin
            return s;
        end else begin
            return s - SW'(1);
        end
    endfunction

    kbd_ascii_decoder #(
        .CASE_INSENSITIVE (CASE_INSENSITIVE)
    ) u_decoder (
        .ascii (kbd_ascii),
        .cmd   (cmd_s)
    );

    // Only the low-to-high transition of kbd_ready issues a command.
    assign strobe_s = kbd_ready & ~kbd_ready_q;

    // Next-state and next-output computation.
    always_comb begin
        state_nxt_s     = state_r;
        pause_nxt_s     = pause;
        direction_nxt_s = direction;
        speed_nxt_s     = speed;
        accepted_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (strobe_s) begin
                    case (cmd_s)
                        CMD_PLAY: begin
                            pause_nxt_s    = 1'b0;
                            accepted_nxt_s = 1'b1;
                        end
                        CMD_PAUSE: begin
                            pause_nxt_s    = 1'b1;
                            accepted_nxt_s = 1'b1;
                        end
                        CMD_FWD: begin
                            direction_nxt_s = 1'b1;
                            accepted_nxt_s  = 1'b1;
                        end
                        CMD_BWD: begin
                            direction_nxt_s = 1'b0;
                            accepted_nxt_s  = 1'b1;
                        end
                        CMD_SPD_UP: begin
                            speed_nxt_s    = speed_up(speed);
                            accepted_nxt_s = 1'b1;
                        end
                        CMD_SPD_DN: begin
                            speed_nxt_s    = speed_down(speed);
                            accepted_nxt_s = 1'b1;
                        end
                        CMD_SPD_DEF: begin
                            speed_nxt_s    = SPEED_DEF;
                            accepted_nxt_s = 1'b1;
                        end
                        CMD_RESTART: begin
                            // Acceptance of R is signalled when the ack arrives.
                            state_nxt_s = RESTART;
                        end
                        default: begin
                            accepted_nxt_s = 1'b0;
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RESTART: begin
                // Strobes are dropped here; only the ack moves the FSM.
                if (restart_ack) begin
                    state_nxt_s    = IDLE;
                    accepted_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = RESTART;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; restart/busy decode the next state so they
    // are registered yet rise on the same edge as the R strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbd_ready_q  <= 1'b0;
            state_r      <= IDLE;
            restart      <= 1'b0;
            busy         <= 1'b0;
            cmd_accepted <= 1'b0;
            pause        <= PAUSE_INIT;
            direction    <= 1'b1;
            speed        <= SPEED_DEF;
        end else begin
            kbd_ready_q  <= kbd_ready;
            state_r      <= state_nxt_s;
            restart      <= (state_nxt_s == RESTART);
            busy         <= (state_nxt_s == RESTART);
            cmd_accepted <= accepted_nxt_s;
            pause        <= pause_nxt_s;
            direction    <= direction_nxt_s;
            speed        <= speed_nxt_s;
        end
    end

endmodule

// File: tb/tb_kbd_cmd_controller.sv
// -----------------------------------------------------------------------------
// tb_kbd_cmd_controller
// Directed bench for kbd_cmd_controller. dut drives the default configuration;
// dut_cs uses CASE_INSENSITIVE=0 and has its own kbd_ready so it only sees the
// keys aimed at it.
// -----------------------------------------------------------------------------
module tb_kbd_cmd_controller;

    logic       clk;
    logic       reset;
    logic       kbd_ready;
    logic       kbd_ready_cs;
    logic [7:0] kbd_ascii;
    logic       restart_ack;

    logic       restart, pause, direction, cmd_accepted, busy;
    logic [2:0] speed;
    logic       restart_cs, pause_cs, direction_cs, cmd_accepted_cs, busy_cs;
    logic [2:0] speed_cs;

    int n_vec;
    int n_err;
    int pulse_cnt;
    int snap;
    logic pulse;

    kbd_cmd_controller #(
        .NUM_SPEEDS (8), .DEFAULT_SPEED (3), .CASE_INSENSITIVE (1), .RESET_PAUSED (1)
    ) dut (
        .clk (clk), .reset (reset), .kbd_ready (kbd_ready), .kbd_ascii (kbd_ascii),
        .restart_ack (restart_ack), .restart (restart), .pause (pause),
        .direction (direction), .speed (speed), .cmd_accepted (cmd_accepted), .busy (busy)
    );

    kbd_cmd_controller #(
        .NUM_SPEEDS (8), .DEFAULT_SPEED (3), .CASE_INSENSITIVE (0), .RESET_PAUSED (1)
    ) dut_cs (
        .clk (clk), .reset (reset), .kbd_ready (kbd_ready_cs), .kbd_ascii (kbd_ascii),
        .restart_ack (restart_ack), .restart (restart_cs), .pause (pause_cs),
        .direction (direction_cs), .speed (speed_cs), .cmd_accepted (cmd_accepted_cs),
        .busy (busy_cs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count cmd_accepted pulses of the main instance (old value read at each edge).
    always @(posedge clk) begin
        if (cmd_accepted === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe on the main instance; pulse = cmd_accepted right after the edge.
    task automatic send_key(input logic [7:0] code, output logic p);
        @(negedge clk);
        kbd_ascii = code;
        kbd_ready = 1'b1;
        @(negedge clk);
        p = cmd_accepted;
        kbd_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0; n_err = 0; pulse_cnt = 0;
        reset = 1'b1; kbd_ready = 1'b0; kbd_ready_cs = 1'b0;
        kbd_ascii = 8'h00; restart_ack = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_restart", 32'(restart), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acc", 32'(cmd_accepted), 32'd0);
        check("rst_pause", 32'(pause), 32'd1);
        check("rst_dir", 32'(direction), 32'd1);
        check("rst_speed", 32'(speed), 32'd3);
        reset = 1'b0;
        @(negedge clk);
        check("idle_acc", 32'(cmd_accepted), 32'd0);

        // ---- E then lowercase b ----
        send_key(8'h45, pulse);
        check("e_pulse", 32'(pulse), 32'd1);
        check("e_pause", 32'(pause), 32'd0);
        check("e_acc_low", 32'(cmd_accepted), 32'd0);
        send_key(8'h62, pulse);
        check("b_pulse", 32'(pulse), 32'd1);
        check("b_dir", 32'(direction), 32'd0);
        check("b_speed", 32'(speed), 32'd3);

        // ---- eight U: 4,5,6,7,7,7,7,7 ----
        snap = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            send_key(8'h55, pulse);
            check("u_speed", 32'(speed), (i < 4) ? 32'(4 + i) : 32'd7);
            check("u_pulse", 32'(pulse), 32'd1);
        end
        check("u_pulse_cnt", 32'(pulse_cnt - snap), 32'd8);
        send_key(8'h4B, pulse);
        check("k_speed", 32'(speed), 32'd3);
        check("k_pulse", 32'(pulse), 32'd1);

        // ---- R with ack held low, D injected ----
        snap = pulse_cnt;
        send_key(8'h52, pulse);
        check("r_nopulse", 32'(pulse), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("r_restart", 32'(restart), 32'd1);
            check("r_busy", 32'(busy), 32'd1);
            check("r_pause", 32'(pause), 32'd0);
            if (i == 5) begin
                kbd_ascii = 8'h44;
                kbd_ready = 1'b1;
            end else if (i == 6) begin
                kbd_ready = 1'b0;
            end else begin
                kbd_ready = kbd_ready;
            end
        end
        check("r_no_pulses", 32'(pulse_cnt - snap), 32'd0);
        restart_ack = 1'b1;
        @(negedge clk);
        restart_ack = 1'b0;
        check("ack_restart", 32'(restart), 32'd0);
        check("ack_busy", 32'(busy), 32'd0);
        check("ack_pulse", 32'(cmd_accepted), 32'd1);
        @(negedge clk);
        check("ack_pulse_end", 32'(cmd_accepted), 32'd0);
        check("ack_pause", 32'(pause), 32'd0);

        // ---- ack in the same cycle as R is not seen ----
        kbd_ascii = 8'h52; kbd_ready = 1'b1; restart_ack = 1'b1;
        @(negedge clk);
        kbd_ready = 1'b0;
        check("same_ack_restart", 32'(restart), 32'd1);
        check("same_ack_acc", 32'(cmd_accepted), 32'd0);
        @(negedge clk);
        restart_ack = 1'b0;
        check("same_ack_done", 32'(restart), 32'd0);
        check("same_ack_pulse", 32'(cmd_accepted), 32'd1);

        // ---- ack while idle is ignored ----
        @(negedge clk);
        restart_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack_restart", 32'(restart), 32'd0);
            check("idle_ack_acc", 32'(cmd_accepted), 32'd0);
        end
        restart_ack = 1'b0;

        // ---- U held high for 50 cycles increments once ----
        snap = pulse_cnt;
        @(negedge clk);
        kbd_ascii = 8'h55; kbd_ready = 1'b1;
        repeat (50) @(negedge clk);
        kbd_ready = 1'b0;
        @(negedge clk);
        check("hold_speed", 32'(speed), 32'd4);
        check("hold_pulses", 32'(pulse_cnt - snap), 32'd1);

        // ---- lowercase u on the case-sensitive instance ----
        kbd_ascii = 8'h75; kbd_ready_cs = 1'b1;
        @(negedge clk);
        kbd_ready_cs = 1'b0;
        check("cs_u_speed", 32'(speed_cs), 32'd3);
        check("cs_u_acc", 32'(cmd_accepted_cs), 32'd0);
        @(negedge clk);
        kbd_ascii = 8'h55; kbd_ready_cs = 1'b1;
        @(negedge clk);
        kbd_ready_cs = 1'b0;
        check("cs_U_speed", 32'(speed_cs), 32'd4);
        check("cs_U_acc", 32'(cmd_accepted_cs), 32'd1);

        // ---- L saturates at 0: 3,2,1,0,0 ----
        for (int i = 0; i < 5; i++) begin
            send_key(8'h4C, pulse);
            check("l_speed", 32'(speed), (i < 4) ? 32'(3 - i) : 32'd0);
            check("l_pulse", 32'(pulse), 32'd1);
        end

        // ---- unknown code Z ----
        send_key(8'h5A, pulse);
        check("z_pulse", 32'(pulse), 32'd0);
        check("z_speed", 32'(speed), 32'd0);
        check("z_pause", 32'(pause), 32'd0);
        check("z_dir", 32'(direction), 32'd0);
        check("z_restart", 32'(restart), 32'd0);

        // ---- async reset mid-RESTART with speed=6, pause=0 ----
        send_key(8'h4B, pulse);
        for (int i = 0; i < 3; i++) send_key(8'h55, pulse);
        check("pre_rst_speed", 32'(speed), 32'd6);
        send_key(8'h52, pulse);
        check("pre_rst_restart", 32'(restart), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_restart", 32'(restart), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_pause", 32'(pause), 32'd1);
        check("async_dir", 32'(direction), 32'd1);
        check("async_speed", 32'(speed), 32'd3);
        // kbd_ready already high at release is taken on the first edge
        kbd_ascii = 8'h45; kbd_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        kbd_ready = 1'b0;
        check("rel_pause", 32'(pause), 32'd0);
        check("rel_pulse", 32'(cmd_accepted), 32'd1);
        check("rel_restart", 32'(restart), 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
